regfile_dump: RTL

- Read-side sequencer for the 8x16 register file. It walks a contiguous, wrapping range of register numbers on the file's read port.
- Each word is captured into an output register and presented on a valid/ready stream to a downstream consumer (debug port, serializer, or memory writer).
- It owns readnum exclusively while busy and never drives the write port.

---
 rtl/regfile_dump.sv | 123 ++++++++++++
 1 files changed

// File: rtl/regfile_dump.sv
// Read-side sequencer for the register file: walks a wrapping range of
// register numbers and streams each word out over valid/ready.
module regfile_dump #(
   parameter int WIDTH  = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] first,
   input  logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] readnum,
   input  logic [WIDTH-1:0]  rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      HOLD,
      DONE
   } state_t;

   localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(2**ADDR_W);
   localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [ADDR_W-1:0] readnum_q, readnum_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic [ADDR_W-1:0] out_addr_q, out_addr_d;
   logic              out_last_q, out_last_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d     = state_q;
      rem_d       = rem_q;
      readnum_d   = readnum_q;
      out_data_d  = out_data_q;
      out_addr_d  = out_addr_q;
      out_last_d  = out_last_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && count != '0) begin
               rem_d     = (count > MAX_CNT) ? MAX_CNT : count;
               readnum_d = first;
               busy_d    = 1'b1;
               state_d   = READ;
            end
         end
         READ: begin
            out_data_d  = rf_data;
            out_addr_d  = readnum_q;
            out_last_d  = (rem_q == ONE);
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (rem_q > ONE) begin
                  rem_d     = rem_q - ONE;
                  readnum_d = readnum_q + 1'b1;
                  state_d   = READ;
               end else begin
                  out_last_d = 1'b0;
                  done_d     = 1'b1;
                  state_d    = DONE;
               end
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         readnum_q   <= '0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         readnum_q   <= readnum_d;
         out_data_q  <= out_data_d;
         out_addr_q  <= out_addr_d;
         out_last_q  <= out_last_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign readnum   = readnum_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign out_last  = out_last_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
